// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Shared types and constants for the AES stage stream wrapper.
//   aes_wrap_state_t : wrapper control states
//   MODE_IN_STREAM   : mode bit index selecting the streamed input path
//   MODE_OUT_STREAM  : mode bit index selecting the streamed output path
// -----------------------------------------------------------------------------
package acc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      COMPUTE,
      DRAIN
   } aes_wrap_state_t;

   localparam int MODE_IN_STREAM  = 1;
   localparam int MODE_OUT_STREAM = 0;

endpackage

// File: rtl/aes_beat_gearbox.sv
// -----------------------------------------------------------------------------
// aes_beat_gearbox
// Word <-> beat shift register with a beat counter. A parallel load replaces the
// whole word; each shift moves the word up by one beat, inserting i_beat at the
// LSB end. The MSB beat of o_word is therefore always the next beat to emit,
// and after WORD_W/BEAT_W shifts the first beat shifted in sits at the MSB end.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_load       parallel load of i_load_word (also clears the beat counter)
//   i_load_word  word to load
//   i_shift      shift by one beat
//   i_beat       beat inserted at the LSB end on a shift
//   o_word       current word
//   o_last       beat counter is on the final beat of the word
// -----------------------------------------------------------------------------
module aes_beat_gearbox
   import acc_pkg::*;
#(
   parameter int WORD_W = 128,
   parameter int BEAT_W = 64
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [WORD_W-1:0] i_load_word,
   input  logic              i_shift,
   input  logic [BEAT_W-1:0] i_beat,
   output logic [WORD_W-1:0] o_word,
   output logic              o_last
);

   localparam int BEATS = WORD_W / BEAT_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [WORD_W-1:0] r_word;
   logic [CNT_W-1:0]  r_cnt;
   logic [WORD_W-1:0] w_shifted;

   generate
      if (BEATS == 1) begin : g_single
         assign w_shifted = i_beat;
      end else begin : g_multi
         assign w_shifted = {r_word[WORD_W-BEAT_W-1:0], i_beat};
      end
   endgenerate

   assign o_last = (r_cnt == CNT_W'(BEATS - 1));
   assign o_word = r_word;

   // NOTE: the data register is reset as well, so a transaction aborted by reset
   // never exposes a stale partial block on the core or result ports.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
         r_cnt  <= '0;
      end else if (i_load) begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values regardless of block ordering.
         r_word <= i_load_word;
         r_cnt  <= '0;
      end else if (i_shift) begin
         r_word <= w_shifted;
         r_cnt  <= o_last ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/aes_stage_stream_wrapper.sv
// -----------------------------------------------------------------------------
// aes_stage_stream_wrapper
// Valid/ready wrapper around one external multi-round AES stage core. Gathers a
// block plus NUM_KEYS round keys (streamed as beats or as one forward bundle),
// pulses core_start, waits for core_done with a timeout, then returns the result
// as beats or as one forward word. Counts completed blocks.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   mode[1:0]                         [1] stream input, [0] stream output
//   in_valid/in_ready/in_data         upstream beat stream (MSB beat first)
//   fwd_in_valid/ready/data           forward bundle {key[N-1..0], data}
//   out_valid/out_ready/out_data      downstream beat stream (MSB beat first)
//   fwd_out_valid/ready/data          forward result word
//   core_start/core_data/core_keys    launch pulse and operands to the core
//   core_done/core_result             single-cycle completion from the core
//   err_timeout                       one-cycle pulse when the core times out
//   blk_count                         completed blocks, wrapping
// -----------------------------------------------------------------------------
module aes_stage_stream_wrapper
   import acc_pkg::*;
#(
   parameter int BEAT_W   = 64,
   parameter int BLOCK_W  = 128,
   parameter int NUM_KEYS = 4,
   parameter int TIMEOUT  = 64
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [1:0]                     mode,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [BEAT_W-1:0]              in_data,
   input  logic                           fwd_in_valid,
   output logic                           fwd_in_ready,
   input  logic [(1+NUM_KEYS)*BLOCK_W-1:0] fwd_in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [BEAT_W-1:0]              out_data,
   output logic                           fwd_out_valid,
   input  logic                           fwd_out_ready,
   output logic [BLOCK_W-1:0]             fwd_out_data,
   output logic                           core_start,
   output logic [BLOCK_W-1:0]             core_data,
   output logic [NUM_KEYS*BLOCK_W-1:0]    core_keys,
   input  logic                           core_done,
   input  logic [BLOCK_W-1:0]             core_result,
   output logic                           err_timeout,
   output logic [31:0]                    blk_count
);

   localparam int BUNDLE_W = (1 + NUM_KEYS) * BLOCK_W;
   localparam int TO_W     = $clog2(TIMEOUT);

   generate
      if (BLOCK_W % BEAT_W != 0) begin : g_bad_beat
         $error("BLOCK_W must be a multiple of BEAT_W");
      end
      if (NUM_KEYS < 1 || NUM_KEYS > 10) begin : g_bad_keys
         $error("NUM_KEYS must be in 1..10");
      end
      if (TIMEOUT < 2) begin : g_bad_timeout
         $error("TIMEOUT must be at least 2");
      end
   endgenerate

   aes_wrap_state_t   r_state;
   aes_wrap_state_t   w_next;
   logic [1:0]        r_mode;
   logic [TO_W-1:0]   r_to_cnt;
   logic [31:0]       r_blk_count;

   logic [BUNDLE_W-1:0] w_load_word;
   logic [BUNDLE_W-1:0] w_load_reg;
   logic                w_load_last;
   logic [BLOCK_W-1:0]  w_res;
   logic                w_drain_last;
   logic                w_in_hs;
   logic                w_fwd_hs;
   logic                w_out_hs;
   logic                w_res_load;

   // The load shift register holds {data, key0, ..., key[N-1]} from MSB to LSB,
   // which is the order beats arrive in. The forward bundle is reordered into
   // the same layout so both input paths share one register.
   assign w_load_word[NUM_KEYS*BLOCK_W +: BLOCK_W] = fwd_in_data[BLOCK_W-1:0];
   assign core_data = w_load_reg[NUM_KEYS*BLOCK_W +: BLOCK_W];
   generate
      for (genvar i = 0; i < NUM_KEYS; i++) begin : g_keys
         assign w_load_word[(NUM_KEYS-1-i)*BLOCK_W +: BLOCK_W] = fwd_in_data[(i+1)*BLOCK_W +: BLOCK_W];
         assign core_keys[i*BLOCK_W +: BLOCK_W] = w_load_reg[(NUM_KEYS-1-i)*BLOCK_W +: BLOCK_W];
      end
   endgenerate

   assign w_in_hs    = in_valid & in_ready;
   assign w_fwd_hs   = fwd_in_valid & fwd_in_ready;
   assign w_out_hs   = out_valid & out_ready;
   assign w_res_load = (r_state == COMPUTE) & core_done;

   aes_beat_gearbox #(.WORD_W(BUNDLE_W), .BEAT_W(BEAT_W)) u_load (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_fwd_hs),
      .i_load_word (w_load_word),
      .i_shift     (w_in_hs),
      .i_beat      (in_data),
      .o_word      (w_load_reg),
      .o_last      (w_load_last)
   );

   aes_beat_gearbox #(.WORD_W(BLOCK_W), .BEAT_W(BEAT_W)) u_drain (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_res_load),
      .i_load_word (core_result),
      .i_shift     (w_out_hs),
      .i_beat      ('0),
      .o_word      (w_res),
      .o_last      (w_drain_last)
   );

   assign out_data     = out_valid ? w_res[BLOCK_W-1 -: BEAT_W] : '0;
   assign fwd_out_data = fwd_out_valid ? w_res : '0;
   assign blk_count    = r_blk_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      w_next        = r_state;
      in_ready      = 1'b0;
      fwd_in_ready  = 1'b0;
      core_start    = 1'b0;
      out_valid     = 1'b0;
      fwd_out_valid = 1'b0;
      err_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            // Live mode decides which valid starts a transaction; it is latched here.
            if (mode[MODE_IN_STREAM] ? in_valid : fwd_in_valid) w_next = LOAD;
         end
         LOAD: begin
            if (r_mode[MODE_IN_STREAM]) begin
               in_ready = 1'b1;
               if (in_valid && w_load_last) w_next = START;
            end else begin
               fwd_in_ready = 1'b1;
               if (fwd_in_valid) w_next = START;
            end
         end
         START: begin
            core_start = 1'b1;
            w_next     = COMPUTE;
         end
         COMPUTE: begin
            if (core_done) begin
               w_next = DRAIN;
            end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
               err_timeout = 1'b1;
               w_next      = IDLE;
            end
         end
         DRAIN: begin
            if (r_mode[MODE_OUT_STREAM]) begin
               out_valid = 1'b1;
               if (out_ready && w_drain_last) w_next = IDLE;
            end else begin
               fwd_out_valid = 1'b1;
               if (fwd_out_ready) w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode      <= '0;
         r_to_cnt    <= '0;
         r_blk_count <= '0;
      end else begin
         if (r_state == IDLE && w_next == LOAD) r_mode <= mode;
         if (r_state == START)        r_to_cnt <= '0;
         else if (r_state == COMPUTE) r_to_cnt <= r_to_cnt + 1'b1;
         // Only a fully drained result counts; a timeout returns to IDLE from COMPUTE.
         if (r_state == DRAIN && w_next == IDLE) r_blk_count <= r_blk_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_aes_stage_stream_wrapper.sv
// -----------------------------------------------------------------------------
// tb_aes_stage_stream_wrapper
// Bench for aes_stage_stream_wrapper with BEAT_W=64, BLOCK_W=128, NUM_KEYS=4,
// TIMEOUT=8. The core is a stub whose result is a fixed word or a keyed mix of
// the operands it was given. All driving and sampling happens on the falling edge.
// -----------------------------------------------------------------------------
module tb_aes_stage_stream_wrapper;

   localparam int BW = 64;
   localparam int KW = 128;
   localparam int NK = 4;
   localparam int TO = 8;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [1:0]            mode;
   logic                  in_valid;
   logic                  in_ready;
   logic [BW-1:0]         in_data;
   logic                  fwd_in_valid;
   logic                  fwd_in_ready;
   logic [(1+NK)*KW-1:0]  fwd_in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [BW-1:0]         out_data;
   logic                  fwd_out_valid;
   logic                  fwd_out_ready;
   logic [KW-1:0]         fwd_out_data;
   logic                  core_start;
   logic [KW-1:0]         core_data;
   logic [NK*KW-1:0]      core_keys;
   logic                  core_done;
   logic [KW-1:0]         core_result;
   logic                  err_timeout;
   logic [31:0]           blk_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [31:0] exp_cnt  = '0;

   int            stub_delay = 1;
   bit            stub_fixed = 1'b0;
   logic [KW-1:0] stub_val   = '0;

   aes_stage_stream_wrapper #(
      .BEAT_W(BW), .BLOCK_W(KW), .NUM_KEYS(NK), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .fwd_in_valid(fwd_in_valid), .fwd_in_ready(fwd_in_ready), .fwd_in_data(fwd_in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .fwd_out_valid(fwd_out_valid), .fwd_out_ready(fwd_out_ready), .fwd_out_data(fwd_out_data),
      .core_start(core_start), .core_data(core_data), .core_keys(core_keys),
      .core_done(core_done), .core_result(core_result),
      .err_timeout(err_timeout), .blk_count(blk_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Keyed mix: each key rotated by a different amount so key order matters.
   function automatic logic [KW-1:0] ref_res(input logic [KW-1:0] b, input logic [NK*KW-1:0] k);
      logic [KW-1:0] r;
      logic [KW-1:0] ki;
      r = b;
      for (int i = 0; i < NK; i++) begin
         ki = k[i*KW +: KW];
         r  = r ^ ((ki << (8*(i+1))) | (ki >> (KW - 8*(i+1))));
      end
      return r;
   endfunction

   // Beat n of the input stream: block first, then key0..key3, each MSB half first.
   function automatic logic [BW-1:0] beat_of(input logic [KW-1:0] b, input logic [NK*KW-1:0] k, input int n);
      logic [KW-1:0] w;
      if (n < 2) w = b;
      else       w = k[((n-2)/2)*KW +: KW];
      return (n % 2 == 0) ? w[KW-1:BW] : w[BW-1:0];
   endfunction

   function automatic logic sig_val(input int w);
      case (w)
         0: return in_ready;
         1: return fwd_in_ready;
         2: return core_start;
         3: return out_valid;
         default: return fwd_out_valid;
      endcase
   endfunction

   task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic wait_sig(input int which, input string nm);
      int t;
      t = 0;
      while (!sig_val(which) && t < 200) begin
         @(negedge clk);
         t++;
      end
      check({"wait_", nm}, sig_val(which), 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_in_ready"},      in_ready,      0);
      check({tag, "_fwd_in_ready"},  fwd_in_ready,  0);
      check({tag, "_out_valid"},     out_valid,     0);
      check({tag, "_out_data"},      out_data,      0);
      check({tag, "_fwd_out_valid"}, fwd_out_valid, 0);
      check({tag, "_fwd_out_data"},  fwd_out_data,  0);
      check({tag, "_core_start"},    core_start,    0);
      check({tag, "_core_data"},     core_data,     0);
      check({tag, "_core_keys"},     core_keys,     0);
      check({tag, "_err_timeout"},   err_timeout,   0);
      check({tag, "_blk_count"},     blk_count,     0);
   endtask

   task automatic send_beat(input logic [BW-1:0] v, input int gap);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = v;
      wait_sig(0, "in_ready");
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // One complete transaction in mode m, checked against exp_res.
   task automatic run_txn(input string tag, input logic [1:0] m, input logic [KW-1:0] blk,
                          input logic [NK*KW-1:0] keys, input int gap, input int stall,
                          input bit rnd, input int delay, input bit fixed,
                          input logic [KW-1:0] exp_res, input bit toggle, input int exp_lat);
      int            acc_cyc;
      int            v_cyc;
      int            g;
      int            s;
      logic [BW-1:0] expb;
      stub_delay = delay;
      stub_fixed = fixed;
      stub_val   = exp_res;
      mode       = m;
      acc_cyc    = 0;
      if (m[1]) begin
         for (int b = 0; b < 2*(1+NK); b++) begin
            g = rnd ? int'($urandom_range(gap, 0)) : gap;
            send_beat(beat_of(blk, keys, b), g);
            if (toggle && b == 0) mode = ~m;
         end
      end else begin
         fwd_in_valid = 1'b1;
         fwd_in_data  = {keys, blk};
         wait_sig(1, "fwd_in_ready");
         acc_cyc = cyc;
         if (toggle) mode = ~m;
         @(negedge clk);
         fwd_in_valid = 1'b0;
         check({tag, "_fwd_in_ready_once"}, fwd_in_ready, 0);
      end
      wait_sig(2, "core_start");
      check({tag, "_core_data"}, core_data, blk);
      check({tag, "_core_keys"}, core_keys, keys);
      s = rnd ? int'($urandom_range(stall, 0)) : stall;
      if (m[0]) begin
         for (int j = 0; j < 2; j++) begin
            expb      = (j == 0) ? exp_res[KW-1:BW] : exp_res[BW-1:0];
            out_ready = 1'b0;
            wait_sig(3, "out_valid");
            repeat (s) begin
               check($sformatf("%s_hold_b%0d", tag, j), out_data, expb);
               @(negedge clk);
            end
            out_ready = 1'b1;
            check($sformatf("%s_out_valid_b%0d", tag, j), out_valid, 1);
            check($sformatf("%s_out_data_b%0d", tag, j), out_data, expb);
            @(negedge clk);
            out_ready = 1'b0;
         end
      end else begin
         fwd_out_ready = 1'b0;
         wait_sig(4, "fwd_out_valid");
         v_cyc = cyc;
         if (exp_lat > 0) check({tag, "_latency"}, v_cyc - acc_cyc + 1, exp_lat);
         repeat (s) begin
            check({tag, "_fwd_hold"}, fwd_out_data, exp_res);
            @(negedge clk);
         end
         fwd_out_ready = 1'b1;
         check({tag, "_fwd_out_data"}, fwd_out_data, exp_res);
         @(negedge clk);
         fwd_out_ready = 1'b0;
      end
      exp_cnt = exp_cnt + 32'd1;
      check({tag, "_blk_count"}, blk_count, exp_cnt);
      check({tag, "_back_idle"}, {out_valid, fwd_out_valid}, 0);
   endtask

   // Core stub: answers core_start with a one-cycle core_done after stub_delay
   // cycles; stub_delay of 0 models a core that never finishes.
   initial begin
      logic [KW-1:0] r;
      core_done   = 1'b0;
      core_result = '0;
      forever begin
         @(negedge clk);
         if (core_start && stub_delay > 0) begin
            r = stub_fixed ? stub_val : ref_res(core_data, core_keys);
            repeat (stub_delay) @(negedge clk);
            core_done   = 1'b1;
            core_result = r;
            @(negedge clk);
            core_done   = 1'b0;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string           tag;
      logic [1:0]      mode;
      logic [KW-1:0]   blk;
      logic [NK*KW-1:0] keys;
      int              gap;
      int              stall;
      int              delay;
      bit              fixed;
      logic [KW-1:0]   exp_res;
      int              exp_lat;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [KW-1:0]    b;
      logic [NK*KW-1:0] k;

      rst_n = 1'b0; mode = 2'b00;
      in_valid = 1'b0; in_data = '0;
      fwd_in_valid = 1'b0; fwd_in_data = '0;
      out_ready = 1'b0; fwd_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      k = {128'h0F0E0D0C_0B0A0908_07060504_03020100, 128'h1F1E1D1C_1B1A1918_17161514_13121110,
           128'h2F2E2D2C_2B2A2928_27262524_23222120, 128'h3F3E3D3C_3B3A3938_37363534_33323130};
      b = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      vecs[0] = '{"ss_fixed", 2'b11, b, k, 0, 0, 3, 1'b1, 128'hA5112233_44556677_8899AABB_CCDDEE5A, 0};
      vecs[1] = '{"ff_lat",   2'b00, b, k, 0, 0, 1, 1'b0, ref_res(b, k), 4};
      vecs[2] = '{"sf_gap",   2'b10, ~b, k, 2, 3, 2, 1'b0, ref_res(~b, k), 0};
      vecs[3] = '{"fs_stall", 2'b01, b, ~k, 0, 5, 1, 1'b0, ref_res(b, ~k), 0};
      vecs[4] = '{"ss_bp",    2'b11, ~b, ~k, 3, 5, 4, 1'b0, ref_res(~b, ~k), 0};
      for (int i = 0; i < 5; i++)
         run_txn(vecs[i].tag, vecs[i].mode, vecs[i].blk, vecs[i].keys, vecs[i].gap,
                 vecs[i].stall, 1'b0, vecs[i].delay, vecs[i].fixed, vecs[i].exp_res,
                 1'b0, vecs[i].exp_lat);

      // Core never answers: abort on the eighth COMPUTE cycle, count unchanged.
      stub_delay   = 0;
      mode         = 2'b00;
      fwd_in_valid = 1'b1;
      fwd_in_data  = {k, b};
      wait_sig(1, "to_fwd_in_ready");
      @(negedge clk);
      fwd_in_valid = 1'b0;
      wait_sig(2, "to_core_start");
      for (int c = 1; c <= TO; c++) begin
         @(negedge clk);
         check($sformatf("timeout_cyc%0d", c), err_timeout, (c == TO));
      end
      @(negedge clk);
      check("timeout_pulse_end", err_timeout, 0);
      check("timeout_no_result", {out_valid, fwd_out_valid}, 0);
      check("timeout_blk_count", blk_count, exp_cnt);
      run_txn("after_to", 2'b00, ~b, k, 0, 0, 1'b0, 2, 1'b0, ref_res(~b, k), 1'b0, 0);

      // Mode input flipped mid-LOAD; transaction finishes in its latched mode.
      run_txn("tog_s", 2'b11, b, k, 1, 2, 1'b0, 1, 1'b0, ref_res(b, k), 1'b1, 0);
      run_txn("tog_f", 2'b00, ~b, ~k, 0, 1, 1'b0, 1, 1'b0, ref_res(~b, ~k), 1'b1, 0);

      // Reset while beat 5 is being offered, then a fresh block.
      mode = 2'b11;
      for (int n = 0; n < 4; n++) send_beat(beat_of(b, k, n), 0);
      in_valid = 1'b1;
      in_data  = beat_of(b, k, 4);
      rst_n    = 1'b0;
      #1;
      check_zero("rst_mid");
      in_valid = 1'b0;
      @(negedge clk);
      rst_n   = 1'b1;
      exp_cnt = '0;
      @(negedge clk);
      run_txn("post_rst", 2'b11, ~b, k, 0, 1, 1'b0, 2, 1'b0, ref_res(~b, k), 1'b0, 0);

      for (int r = 0; r < 16; r++) begin
         b = {$urandom, $urandom, $urandom, $urandom};
         for (int q = 0; q < NK*4; q++) k[q*32 +: 32] = $urandom;
         run_txn($sformatf("rnd%0d", r), 2'($urandom_range(3, 0)), b, k, 3, 4, 1'b1,
                 int'($urandom_range(5, 1)), 1'b0, ref_res(b, k),
                 1'($urandom_range(1, 0)), 0);
      end

      // Counter wrap.
      force dut.r_blk_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_blk_count;
      check("wrap_preload", blk_count, 32'hFFFF_FFFF);
      exp_cnt = 32'hFFFF_FFFF;
      run_txn("wrap", 2'b01, b, k, 0, 0, 1'b0, 1, 1'b0, ref_res(b, k), 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
